// File: rtl/cr_iu_pkg.sv
// cr_iu_pkg: shared change-of-flow FSM states, source ids and PC width
package cr_iu_pkg;
  localparam int PC_W = 31;
  typedef enum logic [1:0] {
    CHGFLW_IDLE  = 2'd0,
    CHGFLW_WAIT  = 2'd1,
    CHGFLW_ISSUE = 2'd2,
    CHGFLW_FLUSH = 2'd3
  } chgflw_state_e;
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_HAD  = 2'd1,
    SRC_EXPT = 2'd2,
    SRC_BR   = 2'd3
  } chgflw_src_e;
endpackage

// File: rtl/cr_iu_chgflw_arb_if.sv
// cr_iu_chgflw_arb_if: redirect requests from HAD/EXPT/BR and the serialized redirect to pcgen
interface cr_iu_chgflw_arb_if;
  import cr_iu_pkg::*;
  logic            had_chgflw_req;
  logic [PC_W-1:0] had_chgflw_pc;
  logic            expt_chgflw_req;
  logic [PC_W-1:0] expt_chgflw_pc;
  logic            br_chgflw_req;
  logic [PC_W-1:0] br_chgflw_pc;
  logic            pcgen_xx_ibus_idle;
  logic            arb_pcgen_chgflw_vld;
  logic [PC_W-1:0] arb_pcgen_chgflw_pc;
  logic            arb_had_ack;
  logic            arb_expt_ack;
  logic            arb_br_ack;
  logic            arb_ctrl_stall;
  logic            arb_busy;
  modport master (
    output had_chgflw_req, had_chgflw_pc, expt_chgflw_req, expt_chgflw_pc,
           br_chgflw_req, br_chgflw_pc, pcgen_xx_ibus_idle,
    input  arb_pcgen_chgflw_vld, arb_pcgen_chgflw_pc, arb_had_ack, arb_expt_ack,
           arb_br_ack, arb_ctrl_stall, arb_busy
  );
  modport slave (
    input  had_chgflw_req, had_chgflw_pc, expt_chgflw_req, expt_chgflw_pc,
           br_chgflw_req, br_chgflw_pc, pcgen_xx_ibus_idle,
    output arb_pcgen_chgflw_vld, arb_pcgen_chgflw_pc, arb_had_ack, arb_expt_ack,
           arb_br_ack, arb_ctrl_stall, arb_busy
  );
endinterface

// File: rtl/cr_iu_chgflw_prio.sv
// cr_iu_chgflw_prio: fixed-priority picker HAD > EXPT > BR, one-hot grant {br,expt,had} and muxed PC
module cr_iu_chgflw_prio
  import cr_iu_pkg::*;
(
  input  logic            had_req,
  input  logic            expt_req,
  input  logic            br_req,
  input  logic [PC_W-1:0] had_pc,
  input  logic [PC_W-1:0] expt_pc,
  input  logic [PC_W-1:0] br_pc,
  output logic [2:0]      gnt,
  output logic [PC_W-1:0] pc
);
  assign gnt = {br_req & ~had_req & ~expt_req, expt_req & ~had_req, had_req};
  assign pc  = had_req ? had_pc : expt_req ? expt_pc : br_req ? br_pc : '0;
endmodule

// File: rtl/cr_iu_chgflw_arb.sv
// cr_iu_chgflw_arb: serializes change-of-flow requests into one redirect strobe per ibus-idle window
module cr_iu_chgflw_arb
  import cr_iu_pkg::*;
#(
  parameter int FLUSH_CYC = 2
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  cr_iu_chgflw_arb_if.slave   bus
);
  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYC - 1);
  chgflw_state_e   state, state_nxt;
  chgflw_src_e     src_q, src_w;
  logic [PC_W-1:0] pc_q, pc_w;
  logic [2:0]      gnt, cnt;
  logic            any_req, issue;
  cr_iu_chgflw_prio u_prio (
    .had_req  (bus.had_chgflw_req),
    .expt_req (bus.expt_chgflw_req),
    .br_req   (bus.br_chgflw_req),
    .had_pc   (bus.had_chgflw_pc),
    .expt_pc  (bus.expt_chgflw_pc),
    .br_pc    (bus.br_chgflw_pc),
    .gnt      (gnt),
    .pc       (pc_w)
  );
  assign any_req = |gnt;
  assign src_w   = gnt[0] ? SRC_HAD : gnt[1] ? SRC_EXPT : gnt[2] ? SRC_BR : SRC_NONE;
  assign issue   = state == CHGFLW_ISSUE;
  // state register
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) state <= CHGFLW_IDLE;
    else           state <= state_nxt;
  // next state: IDLE and WAIT share arbitration; an emptied WAIT falls back to IDLE
  always_comb
    state_nxt = issue                  ? CHGFLW_FLUSH :
                state == CHGFLW_FLUSH  ? (cnt == 3'd0 ? CHGFLW_IDLE : CHGFLW_FLUSH) :
                !any_req               ? CHGFLW_IDLE :
                bus.pcgen_xx_ibus_idle ? CHGFLW_ISSUE : CHGFLW_WAIT;
  // winner latch re-arbitrated every IDLE/WAIT cycle, flush counter loaded on issue
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      src_q <= SRC_NONE;
      pc_q  <= '0;
      cnt   <= '0;
    end else begin
      if (state == CHGFLW_IDLE || state == CHGFLW_WAIT) begin
        src_q <= src_w;
        pc_q  <= any_req ? pc_w : pc_q;
      end
      cnt <= issue ? FLUSH_LD : (state == CHGFLW_FLUSH && cnt != 3'd0) ? cnt - 3'd1 : cnt;
    end
  // outputs decoded from registered state and latches; only stall sees req directly
  always_comb begin
    bus.arb_pcgen_chgflw_vld = issue;
    bus.arb_pcgen_chgflw_pc  = issue ? pc_q : '0;
    bus.arb_had_ack          = issue && src_q == SRC_HAD;
    bus.arb_expt_ack         = issue && src_q == SRC_EXPT;
    bus.arb_br_ack           = issue && src_q == SRC_BR;
    bus.arb_busy             = state != CHGFLW_IDLE;
    bus.arb_ctrl_stall       = any_req || state != CHGFLW_IDLE;
  end
endmodule

// File: tb/tb_cr_iu_chgflw_arb.sv
// tb_cr_iu_chgflw_arb: cycle-by-cycle vector table plus async reset sequence for the redirect arbiter
module tb_cr_iu_chgflw_arb;
  import cr_iu_pkg::*;
  localparam logic [30:0] PC_H = 31'h3abc_def0;
  localparam logic [30:0] PC_E = 31'h0000_0040;
  localparam logic [30:0] PC_B = 31'h0000_0200;
  typedef struct {
    logic        h, e, b, idle;
    logic        vld;
    logic [30:0] pc;
    logic [2:0]  ack;
    logic        stall, busy;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];
  logic [2:0] ack_d = 3'b000;
  cr_iu_chgflw_arb_if bus();
  cr_iu_chgflw_arb #(.FLUSH_CYC(2)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst_n)
      assert (!(ack_d[2] && bus.had_chgflw_req) && !(ack_d[1] && bus.expt_chgflw_req) &&
              !(ack_d[0] && bus.br_chgflw_req))
      else $error("requester kept req asserted the cycle after its ack");
    ack_d <= {bus.arb_had_ack, bus.arb_expt_ack, bus.arb_br_ack};
  end
  task automatic add(input logic h, e, b, idle, vld, input logic [30:0] pc,
                     input logic [2:0] ack, input logic stall, busy);
    vec_t v;
    v.h = h; v.e = e; v.b = b; v.idle = idle; v.vld = vld;
    v.pc = pc; v.ack = ack; v.stall = stall; v.busy = busy;
    tbl.push_back(v);
  endtask
  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask
  task automatic check_outs(input int idx, input logic vld, input logic [30:0] pc,
                            input logic [2:0] ack, input logic stall, busy);
    chk("vld", idx, {31'd0, bus.arb_pcgen_chgflw_vld}, {31'd0, vld});
    chk("pc", idx, {1'b0, bus.arb_pcgen_chgflw_pc}, {1'b0, pc});
    chk("ack", idx, {29'd0, bus.arb_had_ack, bus.arb_expt_ack, bus.arb_br_ack}, {29'd0, ack});
    chk("stall", idx, {31'd0, bus.arb_ctrl_stall}, {31'd0, stall});
    chk("busy", idx, {31'd0, bus.arb_busy}, {31'd0, busy});
  endtask
  task automatic drive(input logic h, e, b, idle);
    bus.had_chgflw_req = h;
    bus.expt_chgflw_req = e;
    bus.br_chgflw_req = b;
    bus.pcgen_xx_ibus_idle = idle;
  endtask
  initial begin
    bus.had_chgflw_pc = PC_H;
    bus.expt_chgflw_pc = PC_E;
    bus.br_chgflw_pc = PC_B;
    drive(0, 0, 0, 1);
    // single BR, ibus idle
    add(0,0,1,1, 0,'0,3'b000, 1,0);
    add(0,0,1,1, 1,PC_B,3'b001, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 0,0);
    // BR while ibus busy for 5 cycles
    add(0,0,1,0, 0,'0,3'b000, 1,0);
    for (int i = 0; i < 4; i++) add(0,0,1,0, 0,'0,3'b000, 1,1);
    add(0,0,1,1, 0,'0,3'b000, 1,1);
    add(0,0,1,1, 1,PC_B,3'b001, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 0,0);
    // EXPT pre-empts BR in WAIT, BR served after flush
    add(0,0,1,0, 0,'0,3'b000, 1,0);
    add(0,0,1,0, 0,'0,3'b000, 1,1);
    add(0,1,1,0, 0,'0,3'b000, 1,1);
    add(0,1,1,1, 0,'0,3'b000, 1,1);
    add(0,1,1,1, 1,PC_E,3'b010, 1,1);
    add(0,0,1,1, 0,'0,3'b000, 1,1);
    add(0,0,1,1, 0,'0,3'b000, 1,1);
    add(0,0,1,1, 0,'0,3'b000, 1,0);
    add(0,0,1,1, 1,PC_B,3'b001, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 0,0);
    // all three together: HAD, EXPT, BR spaced FLUSH_CYC+2 apart
    add(1,1,1,1, 0,'0,3'b000, 1,0);
    add(1,1,1,1, 1,PC_H,3'b100, 1,1);
    add(0,1,1,1, 0,'0,3'b000, 1,1);
    add(0,1,1,1, 0,'0,3'b000, 1,1);
    add(0,1,1,1, 0,'0,3'b000, 1,0);
    add(0,1,1,1, 1,PC_E,3'b010, 1,1);
    add(0,0,1,1, 0,'0,3'b000, 1,1);
    add(0,0,1,1, 0,'0,3'b000, 1,1);
    add(0,0,1,1, 0,'0,3'b000, 1,0);
    add(0,0,1,1, 1,PC_B,3'b001, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 0,0);
    // BR withdrawn during WAIT
    add(0,0,1,0, 0,'0,3'b000, 1,0);
    add(0,0,1,0, 0,'0,3'b000, 1,1);
    add(0,0,0,0, 0,'0,3'b000, 1,1);
    add(0,0,0,1, 0,'0,3'b000, 0,0);
    add(0,0,0,1, 0,'0,3'b000, 0,0);
    #1 rst_n = 1'b0;
    #1 check_outs(-1, 0, '0, 3'b000, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].h, tbl[i].e, tbl[i].b, tbl[i].idle);
      #1 check_outs(i, tbl[i].vld, tbl[i].pc, tbl[i].ack, tbl[i].stall, tbl[i].busy);
      @(posedge clk);
      #1;
    end
    // async reset mid-WAIT
    drive(0, 0, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #1 check_outs(100, 0, '0, 3'b000, 1, 1);
    #2 rst_n = 1'b0;
    drive(0, 0, 0, 1);
    #1 check_outs(101, 0, '0, 3'b000, 0, 0);
    @(posedge clk);
    #1 check_outs(102, 0, '0, 3'b000, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check_outs(103 + i, 0, '0, 3'b000, 0, 0);
      @(posedge clk);
      #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cr_iu_chgflw_arb.md
# cr_iu_chgflw_arb

Change-of-flow arbiter and sequencer for the E902 IU. It accepts PC-redirect requests from three sources: debug (HAD), exception/trap, and the branch unit. It picks one, waits until the instruction bus is idle, and issues a single redirect pulse with the target PC to pcgen. It then holds a short fetch-flush window before accepting the next redirect. It replaces the ad-hoc `ibus_idle` gating at each requester with one serialized path.

## Interface
- `FLUSH_CYC`, default 2: cycles held in FLUSH after a redirect (1–7).
- `forever_cpuclk`  in  1  core clock.
- `cpurst_b`  in  1  reset, asynchronous, active-low.
- `had_chgflw_req`  in  1  debug redirect request; level, held until ack.
- `had_chgflw_pc`  in  31  debug target PC[31:1].
- `expt_chgflw_req`  in  1  exception/trap redirect request; level, held until ack.
- `expt_chgflw_pc`  in  31  trap vector PC[31:1].
- `br_chgflw_req`  in  1  branch/jump redirect request; level, held until ack.
- `br_chgflw_pc`  in  31  branch target PC[31:1].
- `pcgen_xx_ibus_idle`  in  1  instruction bus has no outstanding transfer.
- `arb_pcgen_chgflw_vld`  out  1  one-cycle redirect strobe to pcgen.
- `arb_pcgen_chgflw_pc`  out  31  redirect target, valid with strobe.
- `arb_had_ack`, `arb_expt_ack`, `arb_br_ack`  out  1 each  one-hot, one-cycle grant, coincident with strobe.
- `arb_ctrl_stall`  out  1  pipeline stall while any request is pending or in FLUSH.
- `arb_busy`  out  1  FSM not in IDLE.

## Operation
- Priority is fixed: HAD > EXPT > BR.
- The FSM has states IDLE, WAIT, ISSUE, FLUSH; the encoding is 2-bit.
- IDLE:
  - If any request is present, latch the winner's source id and PC.
  - Go to ISSUE if `pcgen_xx_ibus_idle` is 1 in the same cycle; otherwise go to WAIT.
- WAIT:
  - Re-arbitrate every cycle. A higher-priority request replaces the latched source and PC.
  - A lower-priority request is ignored.
  - If the latched requester drops its request, abandon it: re-arbitrate, and go to IDLE if nothing remains.
  - Go to ISSUE on the first cycle `pcgen_xx_ibus_idle` is 1.
- ISSUE:
  - Drive `arb_pcgen_chgflw_vld`=1 and `arb_pcgen_chgflw_pc` = latched PC.
  - Drive the ack of the latched source only.
  - Load the flush counter with `FLUSH_CYC`-1 and go to FLUSH.
- FLUSH:
  - Decrement the counter each cycle. Go to IDLE when the counter is 0.
  - Requests arriving here wait; they are not latched until IDLE.
- A requester must deassert its req on the cycle after its ack. The block does not check this; the bench asserts it.
- `arb_ctrl_stall` = (any req) | (state != IDLE).
- `arb_busy` = (state != IDLE).
- PC is always 31 bits ([31:1]), passed through unmodified, with no arithmetic.

## Timing
- Reset values: state=IDLE, latched PC=0, source=none, counter=0, all outputs 0.
- Minimum latency from req (with ibus idle) to strobe is 1 cycle: the request is sampled in IDLE and the strobe appears in ISSUE.
- Back-to-back redirect spacing is `FLUSH_CYC`+2 cycles (strobe → next strobe).
- When a new request and ibus idle occur in the same cycle as the FLUSH→IDLE transition, that request is handled in IDLE on the following cycle.
- Reset mid-WAIT or mid-FLUSH returns to IDLE immediately (asynchronous). No strobe or ack is produced.
- When all three requests rise together, only `arb_had_ack` fires. EXPT then waits through FLUSH before being served.
- Outputs are registered from state/latches and have no combinational path from req to strobe. The exception is `arb_ctrl_stall`, which is combinational on the req inputs.

## Structure
- Shared package `cr_iu_pkg`:
  - FSM state constants `CHGFLW_IDLE`/`WAIT`/`ISSUE`/`FLUSH`.
  - Source-id constants `SRC_NONE`/`HAD`/`EXPT`/`BR` (2-bit).
- One natural sub-module, `cr_iu_chgflw_prio`: combinational fixed-priority picker (3 reqs → one-hot grant + muxed PC).
- The FSM, latches and flush counter live in the top.

## Test plan
- Single BR req, PC=0x0000_0400>>1, ibus idle → strobe next cycle with PC=0x200, `arb_br_ack`=1, then `FLUSH_CYC` idle cycles, busy=0.
- BR req with ibus busy for 5 cycles → WAIT for 5 cycles with stall=1, strobe on the 1st cycle ibus is idle, PC unchanged.
- BR in WAIT, EXPT req (PC=0x40) on cycle 2 → strobe carries 0x40 with `arb_expt_ack`; BR is then served after FLUSH.
- HAD, EXPT, BR asserted together, ibus idle → acks in order HAD, EXPT, BR, spaced `FLUSH_CYC`+2 cycles apart.
- `cpurst_b` low during WAIT → all outputs 0 asynchronously; after release with no req, state stays IDLE and no strobe occurs.
- BR req withdrawn during WAIT with no other req → back to IDLE, no strobe, stall drops the same cycle.
